// File: rtl/ifu_pkg.sv
// Shared types and constants for the ifu_fetch instruction fetch stage.
package ifu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int unsigned PC_STEP      = 4;

  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, one buffered instruction,
// redirects squash the in-flight fetch via a stale flag.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IFU_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  input  logic             imem_resp_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inst,
  output logic             out_err,
  output logic [WIDTH-1:0] debug_pc,
  output logic [WIDTH-1:0] debug_inst
);

  ifu_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             stale_q, stale_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d;
  logic [WIDTH-1:0] out_inst_q, out_inst_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] debug_pc_q, debug_pc_d;
  logic [WIDTH-1:0] debug_inst_q, debug_inst_d;

  logic pc_ok;
  logic req_fire;
  logic deliver;

  // Handshake-facing valids come only from registered state, never from inputs.
  assign pc_ok          = pc_aligned(pc_q[1:0]);
  assign imem_req_valid = (state_q == REQ) && pc_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_valid      = (state_q == HOLD);
  assign deliver        = out_valid && out_ready;

  assign out_pc     = out_pc_q;
  assign out_inst   = out_inst_q;
  assign out_err    = out_err_q;
  assign debug_pc   = debug_pc_q;
  assign debug_inst = debug_inst_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_d      = stale_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_err_d    = out_err_q;
    debug_pc_d   = debug_pc_q;
    debug_inst_d = debug_inst_q;

    unique case (state_q)
      BOOT: begin
        state_d = REQ;
      end

      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          stale_d = redirect_valid;
        end else if (!pc_ok && !redirect_valid) begin
          // Misaligned PC never reaches imem; it is reported as a fault instead.
          out_pc_d   = pc_q;
          out_inst_d = '0;
          out_err_d  = 1'b1;
          state_d    = HOLD;
        end
      end

      WAIT: begin
        if (imem_resp_valid) begin
          if (stale_q || redirect_valid) begin
            stale_d = 1'b0;
            state_d = REQ;
          end else begin
            out_pc_d   = pc_q;
            out_inst_d = imem_resp_data;
            out_err_d  = imem_resp_err;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          stale_d = 1'b1;
        end
      end

      HOLD: begin
        if (deliver) begin
          debug_pc_d   = out_pc_q;
          debug_inst_d = out_inst_q;
          pc_d         = pc_q + WIDTH'(PC_STEP);
          state_d      = REQ;
        end else if (redirect_valid) begin
          state_d = REQ;
        end
      end

      default: state_d = BOOT;
    endcase

    // A redirect always wins the next PC, including over a same-cycle delivery.
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      stale_q      <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_err_q    <= 1'b0;
      debug_pc_q   <= '0;
      debug_inst_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_q      <= stale_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_err_q    <= out_err_d;
      debug_pc_q   <= debug_pc_d;
      debug_inst_q <= debug_inst_d;
    end
  end

endmodule
